// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM states, datapath width, ALU/opcode encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DATA_WIDTH = 16;

    // ALUControl encodings; the execute stage takes the divider result on ALU_DIV.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_DIV = 2'b10;
    localparam logic [1:0] ALU_SHL = 2'b11;

    localparam logic [3:0] OP_DIV = 4'b1011;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; ports rem_in/bit_in/divisor in, rem_out/q_bit out.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so shifted < 2*divisor and a non-negative
    // difference fits in WIDTH bits; the top bit of diff is therefore the borrow.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider controller for the Divide instruction.
// Latency: WIDTH+1 cycles from request to done (1 cycle for a zero divisor).
// Backpressure: stall held while a request is accepted and through CALC; flush aborts.
// Ports: clk/rst (sync, active high); start, flush, op_a, op_b in;
//        stall, done, quotient, remainder, div_by_zero out.
module div_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q_bit;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q_bit)
    );

    assign last_step = (count_q == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (start) state_d = (op_b == '0) ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (last_step) state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // Outputs; stall drops in DONE so the pipeline consumes the result that cycle.
    always_comb begin
        stall = ((state_q == DIV_IDLE) && start && !flush) || (state_q == DIV_CALC);
        done  = (state_q == DIV_DONE);
    end

    // Datapath next values; results only change on a completed op.
    always_comb begin
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (!flush) begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        if (op_b != '0) begin
                            dvd_d   = op_a;
                            dvs_d   = op_b;
                            prem_d  = '0;
                            count_d = '0;
                        end else begin
                            quotient_d  = '1;
                            remainder_d = op_a;
                            dbz_d       = 1'b1;
                        end
                    end
                end
                DIV_CALC: begin
                    dvd_d  = {dvd_q[WIDTH-2:0], step_q_bit};
                    prem_d = step_rem;
                    if (last_step) begin
                        // Hold the counter at its last value rather than wrapping.
                        quotient_d  = {dvd_q[WIDTH-2:0], step_q_bit};
                        remainder_d = step_rem;
                        dbz_d       = 1'b0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         stall;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .flush       (flush),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   n_done     = 0;
    int   n_pushed   = 0;
    exp_t last_res;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: plain integer division; divisor zero saturates the quotient.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
            end
        end
    end

    // Entered and left at negedge+2; drives one divide and measures stall/latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int cyc;
        int st;
        int exp_cyc;
        exp_t e;
        e = model(a, b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        sb.push_back(e);
        n_pushed++;
        last_res = e;
        exp_cyc = (b == 0) ? 1 : W + 1;
        cyc = 0;
        st  = 0;
        #1;
        while (1) begin
            if (done) break;
            if (stall) st++;
            if (cyc >= 60) begin
                compared++;
                mismatched++;
                $display("FAIL done_timeout: got no done after %0d cycles expected %0d", cyc, exp_cyc);
                break;
            end
            @(negedge clk);
            #1;
            if (!hold) start = 1'b0;
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("stall_cycles", 32'(st), 32'(exp_cyc));
        check("stall_in_done", 32'(stall), 32'(0));
        start = 1'b0;
        @(negedge clk);
        #2;
        check("idle_done", 32'(done), 32'(0));
        check("idle_stall", 32'(stall), 32'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;
        int           guard;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));

        // Basic, divide-by-zero and edge operands
        run_op(16'd100, 16'd7, 1'b0);
        run_op(16'd5, 16'd0, 1'b0);
        run_op(16'hFFFF, 16'd1, 1'b0);
        run_op(16'd3, 16'hFFFF, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0);

        // Flush in CALC cycle 5: back to IDLE, results retained
        op_a  = 16'd100;
        op_b  = 16'd7;
        start = 1'b1;
        #1;
        check("flush_req_stall", 32'(stall), 32'(1));
        repeat (5) begin
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush_calc_stall", 32'(stall), 32'(1));
        @(negedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_stall", 32'(stall), 32'(0));
        check("flush_done", 32'(done), 32'(0));
        check("flush_hold_q", 32'(quotient), 32'(last_res.q));
        check("flush_hold_r", 32'(remainder), 32'(last_res.r));
        check("flush_hold_z", 32'(div_by_zero), 32'(last_res.z));

        // Flush together with start in IDLE: nothing accepted
        op_a  = 16'd40;
        op_b  = 16'd0;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_start_stall", 32'(stall), 32'(0));
        @(negedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_start_next_stall", 32'(stall), 32'(0));
        check("flush_start_done", 32'(done), 32'(0));
        run_op(16'd9, 16'd2, 1'b0);

        // start held through the whole operation: exactly one done
        run_op(16'd1234, 16'd10, 1'b1);
        run_op(16'd77, 16'd3, 1'b0);

        // Reset in CALC cycle 8
        op_a  = 16'd1000;
        op_b  = 16'd3;
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_quotient", 32'(quotient), 32'(0));
        check("midrst_remainder", 32'(remainder), 32'(0));
        check("midrst_dbz", 32'(div_by_zero), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_stall", 32'(stall), 32'(0));
        @(negedge clk);
        #2;
        check("midrst_no_done", 32'(done), 32'(0));
        run_op(16'd50, 16'd5, 1'b0);

        // Randomized operands, including zero and small divisors
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            ra  = 16'($urandom_range(0, 65535));
            if (sel == 0)      rb = '0;
            else if (sel < 3)  rb = 16'($urandom_range(1, 15));
            else               rb = 16'($urandom_range(1, 65535));
            run_op(ra, rb, (sel == 7));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2;
        check("pending_ops", 32'(sb.size()), 32'(0));
        check("done_count", 32'(n_done), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
